serial_add_sequencer: RTL and testbench
=======================================

// Module: serial_add_sequencer
// PURPOSE
//  Sequences a bit-serial full adder: one carry flop plus sum = a^b^c, carry' = maj(a,b,c).
//  Accepts parallel WIDTH-bit operands over a valid/ready handshake.
//  Feeds the operands LSB-first through the adder cell, one bit per clock.
//  Collects the serial sum bits and returns the parallel sum and carry-out over a second valid/ready handshake.
//  Sits between a parallel requester and the serial adder datapath; supports add and subtract.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>=2); also the number of SHIFT cycles per operation
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      block can accept a request (high only in IDLE)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in (ignored when in_sub=1)
//  in_sub     in   1      1: compute A - B (B inverted, carry init 1)
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  result, bit i = serial sum bit produced in SHIFT cycle i
//  out_cout   out  1      final carry (for sub: 1 = no borrow)
//  busy       out  1      high in SHIFT or DONE
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE; carry, shift regs, bit counter, out_sum, out_cout = 0.
//    Outputs after reset: in_ready=1, out_valid=0, busy=0. Reset wins over every other event.
//    Reset mid-operation discards the operation silently.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE: in_ready=1. On in_valid (accept edge):
//      opa<=in_a; opb<=in_sub ? ~in_b : in_b; carry<=in_sub ? 1 : in_cin; cnt<=0; ->SHIFT.
//  - SHIFT: in_ready=0. Each edge:
//      s = opa[0]^opb[0]^carry; sum_sr<={s,sum_sr[WIDTH-1:1]};
//      carry<=maj(opa[0],opb[0],carry); opa,opb shift right by 1; cnt<=cnt+1.
//      When cnt==WIDTH-1 -> DONE.
//      in_valid during SHIFT/DONE is ignored; the requester holds it, there is no queue.
//  - DONE: out_valid=1; out_sum=sum_sr, out_cout=carry (registered, stable while out_valid).
//      out_ready=1 -> IDLE at next edge. out_ready=0 -> hold DONE indefinitely, outputs unchanged.
//  - Latency: out_valid rises exactly WIDTH edges after the accept edge.
//    Throughput: one op per WIDTH+2 cycles with out_ready tied high.
//  - A new request is never accepted in the same cycle a result is consumed
//    (in_ready depends only on state, no combinational path from out_ready).
//  - Counter width $clog2(WIDTH); compare against WIDTH-1, no wrap past it.
//  - Arithmetic is modulo 2^WIDTH; overflow is reported only via out_cout.
// STRUCTURE
//  - serial_add_pkg: typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t.
//  - Sub-module serial_adder_cell (clk, reset, en, a, b, init, init_val, q, state):
//    holds the carry flop and produces q=a^b^c; the sequencer owns the operand/sum shift
//    registers, counter and FSM.
//  - Carry init uses the cell's init/init_val load on the accept edge.
// TESTING (WIDTH=8)
//  1. a=0x0F, b=0x01, cin=0, sub=0 -> out_sum=0x10, out_cout=0; out_valid 8 edges after accept.
//  2. a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x7F, b=0x80, cin=1 -> sum=0x00, cout=1.
//  3. sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; sub=1, a=0x07, b=0x05, cin=1 -> sum=0x02, cout=1 (cin ignored).
//  4. out_ready=0 for 5 cycles in DONE -> out_valid, out_sum, out_cout stable;
//     in_valid held high meanwhile is not accepted (in_ready=0). Accepted the cycle after out_ready.
//  5. reset asserted at SHIFT cycle 3 -> next edge: in_ready=1, out_valid=0, busy=0, out_sum=0;
//     a following 0x03+0x04 returns 0x07.
//  6. Back-to-back random ops with in_valid/out_ready high -> one result per 10 cycles,
//     each matching a+b+cin (mod 256) and its carry.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add/subtract sequencer.
// Holds the FSM state encoding and the majority helper.
`timescale 1ns/1ps
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } sa_state_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_adder_cell.sv
// One-bit full adder cell with its carry flop.
// Ports: clk, reset, en (advance carry), a, b, init/init_val (carry load), q (sum bit), state (carry).
`timescale 1ns/1ps
module serial_adder_cell
  import serial_add_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic a,
  input  logic b,
  input  logic init,
  input  logic init_val,
  output logic q,
  output logic state
);

  logic carry;

  always_ff @(posedge clk) begin
    if (reset) begin
      carry <= 1'b0;
    end else if (init) begin
      carry <= init_val;
    end else if (en) begin
      carry <= maj3(a, b, carry);
    end
  end

  assign q     = a ^ b ^ carry;
  assign state = carry;

endmodule

// File: rtl/serial_add_sequencer.sv
// Feeds parallel operands LSB-first through a serial adder cell and returns the parallel result.
// Ports: clk, reset, in_* request handshake, out_* result handshake, busy.
`timescale 1ns/1ps
module serial_add_sequencer
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sa_state_t state_q;
  sa_state_t state_d;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum_sr;
  logic [CW-1:0]    cnt;

  logic accept;
  logic shift_en;
  logic last;
  logic sbit;
  logic carry;

  assign accept   = (state_q == IDLE) && in_valid;
  assign shift_en = (state_q == SHIFT);
  assign last     = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE:  in_ready  = 1'b1;
      SHIFT: busy      = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Subtraction is A + ~B + 1: invert B on load, carry seeded by the cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      opa    <= '0;
      opb    <= '0;
      sum_sr <= '0;
      cnt    <= '0;
    end else if (accept) begin
      opa <= in_a;
      opb <= in_sub ? ~in_b : in_b;
      cnt <= '0;
    end else if (shift_en) begin
      opa    <= opa >> 1;
      opb    <= opb >> 1;
      sum_sr <= {sbit, sum_sr[WIDTH-1:1]};
      if (!last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  serial_adder_cell u_cell (
    .clk      (clk),
    .reset    (reset),
    .en       (shift_en),
    .a        (opa[0]),
    .b        (opb[0]),
    .init     (accept),
    .init_val (in_sub | in_cin),
    .q        (sbit),
    .state    (carry)
  );

  assign out_sum  = sum_sr;
  assign out_cout = carry;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized and directed bench for serial_add_sequencer.
// Results are compared with a plain-arithmetic add/subtract model.
`timescale 1ns/1ps
module tb_serial_add_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_add_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  // {cout, sum}: A+B+cin, or A-B as A + (2^W-1-B) + 1.
  function automatic logic [W:0] model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin,
    input logic         sub
  );
    int unsigned r;
    if (sub) r = int'(a) + ((1 << W) - 1 - int'(b)) + 1;
    else     r = int'(a) + int'(b) + int'(cin);
    return r[W:0];
  endfunction

  // Drives one request; returns the result and edges from accept to out_valid.
  task automatic run_op(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    input  logic         rdy,
    output logic [W-1:0] sum,
    output logic         cout,
    output int           lat,
    output bit           ok
  );
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    in_sub    = sub;
    out_ready = rdy;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    ok   = out_valid && (k < 50);
    sum  = out_sum;
    cout = out_cout;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags got=%b exp=100", {in_ready, out_valid, busy});
    end
    tests++;
    if ({out_cout, out_sum} !== 9'h000) begin
      fails++;
      $display("FAIL reset_result got=%h exp=000", {out_cout, out_sum});
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [6] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h07, 8'h80};
    logic [W-1:0] vb [6] = '{8'h01, 8'h01, 8'h80, 8'h07, 8'h05, 8'h80};
    logic         vc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W:0]   ve [6] = '{9'h010, 9'h100, 9'h100, 9'h0FE, 9'h102, 9'h100};
    logic [W-1:0] s;
    logic         c;
    int           lat;
    bit           ok;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vc[i], vs[i], 1'b1, s, c, lat, ok);
      tests++;
      if (!ok || {c, s} !== ve[i]) begin
        fails++;
        $display("FAIL directed%0d got=%h exp=%h ok=%0d", i, {c, s}, ve[i], ok);
      end
      tests++;
      if (lat != W) begin
        fails++;
        $display("FAIL latency%0d got=%0d exp=%0d", i, lat, W);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic         ci, sb, c;
    logic [W:0]   e;
    int           lat;
    bit           ok;
    for (int i = 0; i < 8; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ci = 1'($urandom);
      sb = 1'($urandom);
      e  = model(a, b, ci, sb);
      run_op(a, b, ci, sb, 1'b1, s, c, lat, ok);
      tests++;
      if (!ok || {c, s} !== e) begin
        fails++;
        $display("FAIL random a=%h b=%h cin=%b sub=%b got=%h exp=%h",
                 a, b, ci, sb, {c, s}, e);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] s0, s;
    logic         c0, c;
    logic [W-1:0] na, nb;
    int           lat;
    bit           ok;
    run_op(8'hC3, 8'h5A, 1'b1, 1'b0, 1'b0, s0, c0, lat, ok);
    tests++;
    if (!ok || {c0, s0} !== model(8'hC3, 8'h5A, 1'b1, 1'b0)) begin
      fails++;
      $display("FAIL bp_first got=%h exp=%h", {c0, s0},
               model(8'hC3, 8'h5A, 1'b1, 1'b0));
    end
    na = W'($urandom);
    nb = W'($urandom);
    in_a     = na;
    in_b     = nb;
    in_cin   = 1'b0;
    in_sub   = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({out_valid, in_ready} !== 2'b10 || {out_cout, out_sum} !== {c0, s0}) begin
        fails++;
        $display("FAIL bp_hold%0d vld_rdy=%b exp=10 res=%h exp=%h",
                 i, {out_valid, in_ready}, {out_cout, out_sum}, {c0, s0});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL bp_release got=%b exp=10", {in_ready, out_valid});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if ({busy, in_ready} !== 2'b10) begin
      fails++;
      $display("FAIL bp_accept got=%b exp=10", {busy, in_ready});
    end
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    s = out_sum;
    c = out_cout;
    tests++;
    if (lat != W || {c, s} !== model(na, nb, 1'b0, 1'b1)) begin
      fails++;
      $display("FAIL bp_second got=%h exp=%h lat=%0d", {c, s},
               model(na, nb, 1'b0, 1'b1), lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] s;
    logic         c;
    int           lat;
    bit           ok;
    @(posedge clk); #1;
    in_a      = 8'hAA;
    in_b      = 8'h55;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_sum !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset flags=%b exp=100 sum=%h exp=00",
               {in_ready, out_valid, busy}, out_sum);
    end
    run_op(8'h03, 8'h04, 1'b0, 1'b0, 1'b1, s, c, lat, ok);
    tests++;
    if (!ok || {c, s} !== 9'h007) begin
      fails++;
      $display("FAIL after_reset got=%h exp=007", {c, s});
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] q[$];
    logic [W:0] e;
    int         last_cyc;
    int         nres;
    last_cyc  = -1;
    nres      = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 125; cyc++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL b2b_unexpected got=%h", {out_cout, out_sum});
        end else begin
          e = q.pop_front();
          if ({out_cout, out_sum} !== e) begin
            fails++;
            $display("FAIL b2b_result got=%h exp=%h", {out_cout, out_sum}, e);
          end
        end
        if (last_cyc >= 0) begin
          tests++;
          if (cyc - last_cyc != W + 2) begin
            fails++;
            $display("FAIL b2b_period got=%0d exp=%0d", cyc - last_cyc, W + 2);
          end
        end
        last_cyc = cyc;
        nres++;
      end
      if (in_ready) begin
        in_a   = W'($urandom);
        in_b   = W'($urandom);
        in_cin = 1'($urandom);
        in_sub = 1'b0;
        q.push_back(model(in_a, in_b, in_cin, 1'b0));
      end
    end
    in_valid = 1'b0;
    tests++;
    if (nres < 11) begin
      fails++;
      $display("FAIL b2b_count got=%0d exp>=11", nres);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
